slot_alloc_mgr: RTL and testbench
=================================

// Module: slot_alloc_mgr
// PURPOSE
// Sequential owner of the buffer-slot occupancy vector.
// - Allocate: returns the lowest free slot index, with NUM_SLOTS meaning "none free".
//   This is the same index encoding the first-zero priority decode uses.
// - Release: turns an index back into a one-hot clear of the occupancy vector.
// - Sits between the packet writer (allocates) and the packet reader (releases).
//
// PARAMETERS
// NUM_SLOTS  8  number of tracked slots (occupancy vector width)
// IDX_W      4  index width; must satisfy 2**IDX_W > NUM_SLOTS so the "none" code NUM_SLOTS fits
//
// PORTS
// clk        in   1          single clock, rising edge
// rst_n      in   1          asynchronous active-low reset
// alloc_req  in   1          request one slot this cycle
// alloc_gnt  out  1          registered: slot granted (1-cycle pulse per request)
// alloc_idx  out  IDX_W      registered: granted index; NUM_SLOTS when no grant
// alloc_fail out  1          registered: request seen while no slot free (1-cycle pulse)
// rel_valid  in   1          release rel_idx this cycle
// rel_idx    in   IDX_W      slot index to release
// rel_err    out  1          registered: illegal release (see CONFIGURATION)
// occ        out  NUM_SLOTS  occupancy vector, bit=1 occupied
// free_cnt   out  IDX_W      number of free slots
// full       out  1          free_cnt==0
// empty      out  1          free_cnt==NUM_SLOTS
//
// BEHAVIOUR
// - Reset (async assert, sync-to-clk deassert handled upstream):
//   occ=0, free_cnt=NUM_SLOTS, alloc_gnt=0, alloc_idx=NUM_SLOTS, alloc_fail=0, rel_err=0.
// - Allocation, 1-cycle latency:
//   - On an edge with alloc_req=1, pick the lowest i with occ[i]==0, using occ as it was before the edge.
//   - If found: occ[i]<=1, alloc_gnt<=1, alloc_idx<=i.
//   - Else: alloc_gnt<=0, alloc_idx<=NUM_SLOTS, alloc_fail<=1.
// - Idle cycles (alloc_req=0): alloc_gnt<=0, alloc_fail<=0, alloc_idx<=NUM_SLOTS.
// - Release:
//   - On an edge with rel_valid=1, rel_idx<NUM_SLOTS and occ[rel_idx]==1: occ[rel_idx]<=0.
//     The one-hot decode of rel_idx is ANDed into a clear mask.
//   - Out-of-range rel_idx, or a release of a free slot, leaves occ unchanged.
// - Simultaneous alloc and release in one cycle:
//   - The released slot is NOT visible to that cycle's allocation; it is reusable from the next edge.
//   - Full + alloc_req + valid release gives alloc_fail=1 that cycle, with the slot freed.
// - free_cnt is registered and updated in the same edge as occ:
//   free_cnt <= free_cnt + eff_rel - eff_alloc, where eff_* are 1 only for effective operations.
//   - free_cnt stays in 0..NUM_SLOTS.
//   - Simultaneous effective alloc and release leaves it unchanged.
// - full and empty are combinational from free_cnt.
// - occ and free_cnt must stay consistent: free_cnt == NUM_SLOTS - popcount(occ) at all times.
// - Reset mid-operation: all state clears immediately; any grant in flight is lost.
//
// CONFIGURATION
// SLOT_DBL_FREE_CHK_EN
// - Defined: rel_err<=1 for one cycle on rel_valid with rel_idx>=NUM_SLOTS or occ[rel_idx]==0.
//   The occ update is still suppressed.
// - Undefined: rel_err is tied to 0 and illegal releases are silently ignored.
//
// TESTING
// - Reset, then alloc_req high for 8 cycles -> alloc_idx 0,1,..,7 with alloc_gnt=1; full=1, free_cnt=0.
// - Full, alloc_req=1 -> alloc_gnt=0, alloc_idx=8, alloc_fail=1 for one cycle; occ=8'hFF unchanged.
// - occ=8'hFF, release idx 5 then alloc -> occ=8'hDF after release; next alloc grants idx 5 and occ=8'hFF.
// - occ=8'hFF, alloc_req=1 and release idx 2 in the same cycle ->
//   alloc_fail=1, occ=8'hFB, free_cnt=1; next alloc grants 2.
// - occ=8'h0F, release idx 6 with SLOT_DBL_FREE_CHK_EN -> rel_err=1 one cycle, occ stays 8'h0F.
//   Without the macro -> rel_err stays 0.
// - Assert rst_n=0 mid-burst with occ=8'h3F -> occ=0, free_cnt=8 and alloc_idx=8 immediately (async).

Source files
------------

// File: rtl/slot_alloc_mgr.sv
// slot_alloc_mgr: buffer-slot occupancy owner with lowest-free allocation and indexed release.
// Optional SLOT_DBL_FREE_CHK_EN flags releases of free or out-of-range slots on rel_err.
module slot_alloc_mgr #(
  parameter int NUM_SLOTS = 8,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [IDX_W-1:0]     alloc_idx,
  output logic                 alloc_fail,
  input  logic                 rel_valid,
  input  logic [IDX_W-1:0]     rel_idx,
  output logic                 rel_err,
  output logic [NUM_SLOTS-1:0] occ,
  output logic [IDX_W-1:0]     free_cnt,
  output logic                 full,
  output logic                 empty
);
  localparam logic [IDX_W-1:0] NONE = IDX_W'(NUM_SLOTS);
  logic [NUM_SLOTS-1:0] occ_q, occ_d, set_oh, clr_oh;
  logic [IDX_W-1:0]     free_q, free_d, idx_q, idx_d, first_free;
  logic                 gnt_q, gnt_d, fail_q, fail_d, found, eff_alloc, eff_rel;
  always_comb begin
    first_free = NONE;
    found      = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (!occ_q[i]) begin
        first_free = IDX_W'(i);
        found      = 1'b1;
      end
  end
  // Shifting past the vector width yields zero, so out-of-range indices clear nothing.
  assign clr_oh    = rel_valid ? (NUM_SLOTS'(1) << rel_idx) & occ_q : '0;
  assign eff_rel   = |clr_oh;
  assign eff_alloc = alloc_req & found;
  assign set_oh    = eff_alloc ? NUM_SLOTS'(1) << first_free : '0;
  assign occ_d     = (occ_q | set_oh) & ~clr_oh;
  assign free_d    = free_q + IDX_W'(eff_rel) - IDX_W'(eff_alloc);
  assign gnt_d     = eff_alloc;
  assign idx_d     = eff_alloc ? first_free : NONE;
  assign fail_d    = alloc_req & ~found;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= '0;
      free_q <= NONE;
      gnt_q  <= 1'b0;
      idx_q  <= NONE;
      fail_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      free_q <= free_d;
      gnt_q  <= gnt_d;
      idx_q  <= idx_d;
      fail_q <= fail_d;
    end
  end
`ifdef SLOT_DBL_FREE_CHK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= rel_valid & ~eff_rel;
  end
  assign rel_err = err_q;
`else
  assign rel_err = 1'b0;
`endif
  assign occ        = occ_q;
  assign free_cnt   = free_q;
  assign alloc_gnt  = gnt_q;
  assign alloc_idx  = idx_q;
  assign alloc_fail = fail_q;
  assign full       = free_q == '0;
  assign empty      = free_q == NONE;
endmodule

// File: tb/tb_slot_alloc_mgr.sv
// tb_slot_alloc_mgr: directed and random checks of slot_alloc_mgr against a set-based model.
module tb_slot_alloc_mgr;
  logic       clk = 1'b0;
  logic       rst_n, alloc_req, rel_valid;
  logic [3:0] rel_idx;
  logic       alloc_gnt, alloc_fail, rel_err, full, empty;
  logic [3:0] alloc_idx, free_cnt;
  logic [7:0] occ;
  int checks = 0;
  int failures = 0;
  logic [7:0] m_occ;
  logic       e_gnt, e_fail, e_err;
  logic [3:0] e_idx;
`ifdef SLOT_DBL_FREE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  slot_alloc_mgr #(.NUM_SLOTS(8), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_idx(alloc_idx), .alloc_fail(alloc_fail), .rel_valid(rel_valid),
    .rel_idx(rel_idx), .rel_err(rel_err), .occ(occ), .free_cnt(free_cnt),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".occ"}, 32'(occ), 32'(m_occ));
    chk({tag, ".free_cnt"}, 32'(free_cnt), 32'(8 - $countones(m_occ)));
    chk({tag, ".full"}, 32'(full), 32'(m_occ == 8'hFF));
    chk({tag, ".empty"}, 32'(empty), 32'(m_occ == 8'h00));
    chk({tag, ".gnt"}, 32'(alloc_gnt), 32'(e_gnt));
    chk({tag, ".idx"}, 32'(alloc_idx), 32'(e_idx));
    chk({tag, ".fail"}, 32'(alloc_fail), 32'(e_fail));
    chk({tag, ".rel_err"}, 32'(rel_err), 32'(e_err));
  endtask

  // One clock cycle: drive, let the edge happen, advance the model from pre-edge state, check.
  task automatic step(input string tag, input logic a, input logic v, input logic [3:0] r);
    int  lf;
    bit  ok;
    alloc_req = a; rel_valid = v; rel_idx = r;
    @(posedge clk);
    lf = -1;
    for (int i = 7; i >= 0; i--) if (!m_occ[i]) lf = i;
    ok     = v && (r < 8) && m_occ[r[2:0]];
    e_gnt  = a && (lf >= 0);
    e_idx  = e_gnt ? 4'(lf) : 4'd8;
    e_fail = a && (lf < 0);
    e_err  = CHK && v && !ok;
    if (e_gnt) m_occ[lf] = 1'b1;
    if (ok) m_occ[r[2:0]] = 1'b0;
    #1 check_all(tag);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_occ = '0; e_gnt = 0; e_idx = 4'd8; e_fail = 0; e_err = 0;
  endtask

  initial begin
    alloc_req = 0; rel_valid = 0; rel_idx = '0; rst_n = 0;
    model_reset();
    #12 check_all("reset");
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 8; i++) step($sformatf("fill%0d", i), 1, 0, 0);
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.occ", 32'(occ), 32'hFF);
    step("full_alloc", 1, 0, 0);
    chk("full_alloc.idx", 32'(alloc_idx), 32'd8);
    step("idle", 0, 0, 0);
    step("rel5", 0, 1, 4'd5);
    chk("rel5.occ", 32'(occ), 32'hDF);
    step("realloc5", 1, 0, 0);
    chk("realloc5.idx", 32'(alloc_idx), 32'd5);
    step("alloc_rel2", 1, 1, 4'd2);
    chk("alloc_rel2.occ", 32'(occ), 32'hFB);
    chk("alloc_rel2.fail", 32'(alloc_fail), 32'd1);
    step("realloc2", 1, 0, 0);
    chk("realloc2.idx", 32'(alloc_idx), 32'd2);
    for (int i = 4; i < 8; i++) step($sformatf("drain%0d", i), 0, 1, 4'(i));
    step("dbl_free6", 0, 1, 4'd6);
    chk("dbl_free6.occ", 32'(occ), 32'h0F);
    step("oor_rel", 0, 1, 4'd9);
    step("after_err", 0, 0, 0);
    step("grow4", 1, 0, 0);
    step("grow5", 1, 0, 0);
    chk("grow.occ", 32'(occ), 32'h3F);
    alloc_req = 1;
    #2 rst_n = 0;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk) rst_n = 1;
    for (int n = 0; n < 400; n++)
      step($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 9)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
